mrx_sync_ctrl: RTL and testbench

MRX_SYNC_CTRL -- requirements
Module: mrx_sync_ctrl

---
 rtl/mrx_sync_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mrx_sync_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrx_sync_ctrl.sv
// MIPI RX frame sync controller: clears the receiver, searches for frame starts, tracks and locks.
// Optional flywheel resync pulses on LOCKED timeouts are enabled by defining MRX_SYNC_FLYWHEEL_EN.
module mrx_sync_ctrl #(
    parameter int CLR_LEN = 16,
    parameter int LOCK_N  = 3,
    parameter int LOSS_N  = 2,
    parameter int TOL     = 64
) (
    input  logic        PCK,
    input  logic        RST,
    input  logic        EN,
    input  logic [21:0] FRM_LEN,
    input  logic        MRX_FLAG_RE,
    input  logic        ERR_CLR,
    output logic        MRX_CLEAR,
    output logic        SYNC_VLOCK,
    output logic        LOCK,
    output logic [2:0]  STATE,
    output logic [7:0]  ERR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SEARCH = 3'd2,
        S_TRACK  = 3'd3,
        S_LOCKED = 3'd4,
        S_LOST   = 3'd5
    } state_t;

    localparam logic [22:0] TOL_W    = 23'(TOL);
    localparam logic [21:0] RELOAD   = 22'(TOL + 1);
    localparam logic [2:0]  LOCK_W   = 3'(LOCK_N);
    localparam logic [2:0]  LOSS_W   = 3'(LOSS_N);
    localparam logic [7:0]  CLR_LAST = 8'(CLR_LEN - 1);

    state_t      state;
    logic [21:0] pcnt;
    logic [2:0]  good_cnt;
    logic [2:0]  miss_cnt;
    logic [7:0]  clr_cnt;

    logic [22:0] frm_w;
    logic [22:0] win_lo;
    logic [22:0] win_hi;
    logic [22:0] tmo_val;
    logic        pulse;
    logic        timeout;
    logic        good;
    logic        err_evt;
    logic        fly_evt;

    assign frm_w   = {1'b0, FRM_LEN};
    assign win_hi  = frm_w + TOL_W;
    assign win_lo  = (frm_w >= TOL_W) ? (frm_w - TOL_W) : '0;
    assign tmo_val = win_hi + 23'd1;

    // Pulses only count while looking for frames; a pulse always beats a coincident timeout.
    assign pulse   = MRX_FLAG_RE && (state == S_SEARCH || state == S_TRACK || state == S_LOCKED);
    assign timeout = !MRX_FLAG_RE && (state == S_TRACK || state == S_LOCKED)
                     && ({1'b0, pcnt} == tmo_val);
    assign good    = ({1'b0, pcnt} >= win_lo) && ({1'b0, pcnt} <= win_hi);
    assign err_evt = EN && (state == S_TRACK || state == S_LOCKED)
                     && ((pulse && !good) || timeout);

`ifdef MRX_SYNC_FLYWHEEL_EN
    assign fly_evt = EN && (state == S_LOCKED) && timeout;
`else
    assign fly_evt = 1'b0;
`endif

    assign STATE = state;

    always_ff @(posedge PCK) begin
        if (RST) begin
            state      <= S_IDLE;
            MRX_CLEAR  <= 1'b0;
            SYNC_VLOCK <= 1'b0;
            LOCK       <= 1'b0;
            ERR_CNT    <= '0;
            pcnt       <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            clr_cnt    <= '0;
        end else begin
            SYNC_VLOCK <= fly_evt;

            // Timeout reload keeps the flywheel period equal to the nominal frame length.
            if (pulse)
                pcnt <= 22'd1;
            else if (timeout)
                pcnt <= RELOAD;
            else if (pcnt != '1)
                pcnt <= pcnt + 22'd1;

            if (ERR_CLR)
                ERR_CNT <= '0;
            else if (err_evt && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;

            if (!EN) begin
                state     <= S_IDLE;
                MRX_CLEAR <= 1'b0;
                LOCK      <= 1'b0;
                good_cnt  <= '0;
                miss_cnt  <= '0;
                clr_cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_CLEAR;
                        MRX_CLEAR <= 1'b1;
                        clr_cnt   <= '0;
                    end
                    S_CLEAR: begin
                        if (clr_cnt == CLR_LAST) begin
                            state     <= S_SEARCH;
                            MRX_CLEAR <= 1'b0;
                            clr_cnt   <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 8'd1;
                        end
                    end
                    S_SEARCH: begin
                        if (pulse) begin
                            state    <= S_TRACK;
                            good_cnt <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (pulse && good) begin
                            good_cnt <= good_cnt + 3'd1;
                            if (good_cnt + 3'd1 == LOCK_W) begin
                                state    <= S_LOCKED;
                                LOCK     <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (pulse) begin
                            good_cnt <= '0;
                        end else if (timeout) begin
                            state <= S_SEARCH;
                        end
                    end
                    S_LOCKED: begin
                        if (pulse && good) begin
                            miss_cnt <= '0;
                        end else if (pulse || timeout) begin
                            miss_cnt <= miss_cnt + 3'd1;
                            if (miss_cnt + 3'd1 == LOSS_W) begin
                                state <= S_LOST;
                                LOCK  <= 1'b0;
                            end
                        end
                    end
                    S_LOST: begin
                        state     <= S_CLEAR;
                        MRX_CLEAR <= 1'b1;
                        clr_cnt   <= '0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        MRX_CLEAR <= 1'b0;
                        LOCK      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mrx_sync_ctrl.sv
// Self-checking bench for mrx_sync_ctrl: time-stamp based reference model plus directed scenarios.
module tb_mrx_sync_ctrl;

    localparam int FL    = 1000;
    localparam int TOLV  = 4;
    localparam int LOCKN = 3;
    localparam int LOSSN = 2;
    localparam int CLRL  = 16;
    localparam int WLO   = (FL > TOLV) ? FL - TOLV : 0;
    localparam int WHI   = FL + TOLV;

    logic        PCK = 1'b0;
    logic        RST;
    logic        EN;
    logic [21:0] FRM_LEN;
    logic        MRX_FLAG_RE;
    logic        ERR_CLR;
    logic        MRX_CLEAR;
    logic        SYNC_VLOCK;
    logic        LOCK;
    logic [2:0]  STATE;
    logic [7:0]  ERR_CNT;

    int checks = 0;
    int errors = 0;

    always #5 PCK = ~PCK;

    mrx_sync_ctrl #(
        .CLR_LEN(CLRL),
        .LOCK_N (LOCKN),
        .LOSS_N (LOSSN),
        .TOL    (TOLV)
    ) dut (
        .PCK        (PCK),
        .RST        (RST),
        .EN         (EN),
        .FRM_LEN    (FRM_LEN),
        .MRX_FLAG_RE(MRX_FLAG_RE),
        .ERR_CLR    (ERR_CLR),
        .MRX_CLEAR  (MRX_CLEAR),
        .SYNC_VLOCK (SYNC_VLOCK),
        .LOCK       (LOCK),
        .STATE      (STATE),
        .ERR_CNT    (ERR_CNT)
    );

    // Reference model: the frame period is edge number minus a reference edge.
    int edge_no = 0;
    int ref_e   = 0;
    int m_st    = 0;
    int m_good  = 0;
    int m_miss  = 0;
    int m_left  = 0;
    int m_err   = 0;
    bit m_sync  = 1'b0;
    bit m_valid = 1'b0;
    int per;
    bit acc, ok, tmo, bad;

    always @(posedge PCK) begin
        edge_no++;
        if (RST) begin
            m_st = 0; m_good = 0; m_miss = 0; m_left = 0; m_err = 0; m_sync = 1'b0;
            ref_e = edge_no + 1;
            m_valid = 1'b1;
        end else begin
            per  = edge_no - ref_e;
            acc  = MRX_FLAG_RE && (m_st == 2 || m_st == 3 || m_st == 4);
            ok   = (per >= WLO) && (per <= WHI);
            tmo  = !MRX_FLAG_RE && (m_st == 3 || m_st == 4) && (per == WHI + 1);
            bad  = 1'b0;
            m_sync = 1'b0;
            if (acc)
                ref_e = edge_no;
            else if (tmo)
                ref_e = edge_no - TOLV;
            if (!EN) begin
                m_st = 0; m_good = 0; m_miss = 0;
            end else begin
                case (m_st)
                    0: begin m_st = 1; m_left = CLRL; end
                    1: begin m_left--; if (m_left == 0) m_st = 2; end
                    2: if (acc) begin m_st = 3; m_good = 0; end
                    3: begin
                        if (acc && ok) begin
                            m_good++;
                            if (m_good == LOCKN) begin m_st = 4; m_miss = 0; end
                        end else if (acc) begin
                            m_good = 0; bad = 1'b1;
                        end else if (tmo) begin
                            bad = 1'b1; m_st = 2;
                        end
                    end
                    4: begin
                        if (acc && ok) begin
                            m_miss = 0;
                        end else if (acc || tmo) begin
                            m_miss++; bad = 1'b1;
                            if (m_miss == LOSSN) m_st = 5;
                        end
`ifdef MRX_SYNC_FLYWHEEL_EN
                        if (tmo) m_sync = 1'b1;
`endif
                    end
                    5: begin m_st = 1; m_left = CLRL; end
                    default: m_st = 0;
                endcase
            end
            if (ERR_CLR)
                m_err = 0;
            else if (bad && m_err < 255)
                m_err++;
        end
    end

    always @(negedge PCK) begin
        if (m_valid) begin
            checks++;
            if (MRX_CLEAR !== (m_st == 1) || SYNC_VLOCK !== m_sync || LOCK !== (m_st == 4)
                || STATE !== 3'(m_st) || ERR_CNT !== 8'(m_err)) begin
                errors++;
                $display("FAIL model t=%0t: dut clr=%b sync=%b lock=%b state=%0d err=%0d, model clr=%b sync=%b lock=%b state=%0d err=%0d",
                         $time, MRX_CLEAR, SYNC_VLOCK, LOCK, STATE, ERR_CNT,
                         (m_st == 1), m_sync, (m_st == 4), m_st, m_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCK);
        #2;
    endtask

    // Pulse sampled exactly 'p' edges after the previous pulse edge.
    task automatic gap(input int p);
        repeat (p - 1) step();
        MRX_FLAG_RE = 1'b1;
        step();
        MRX_FLAG_RE = 1'b0;
    endtask

    task automatic finish_clear();
        repeat (CLRL) step();
        chk("clear_to_search", int'(STATE), 2);
    endtask

    int n;
    int syncs;

    initial begin
        RST = 1'b1; EN = 1'b0; MRX_FLAG_RE = 1'b0; ERR_CLR = 1'b0; FRM_LEN = 22'(FL);
        repeat (3) step();
        chk("rst_state", int'(STATE), 0);
        chk("rst_lock", int'(LOCK), 0);
        chk("rst_clear", int'(MRX_CLEAR), 0);
        chk("rst_err", int'(ERR_CNT), 0);
        chk("rst_sync", int'(SYNC_VLOCK), 0);
        RST = 1'b0;
        step();
        chk("idle_hold", int'(STATE), 0);

        // Enable: CLEAR for exactly CLR_LEN cycles; a pulse inside CLEAR is ignored
        EN = 1'b1;
        step();
        chk("clear_entry_state", int'(STATE), 1);
        chk("clear_entry_out", int'(MRX_CLEAR), 1);
        n = 0;
        while (MRX_CLEAR && n < 100) begin
            n++;
            MRX_FLAG_RE = (n == 5);
            step();
        end
        MRX_FLAG_RE = 1'b0;
        chk("clear_len", n, 16);
        chk("search_state", int'(STATE), 2);

        // Clean lock
        gap(1);
        chk("track_entry", int'(STATE), 3);
        gap(1000);
        gap(1003);
        chk("track_2good", int'(STATE), 3);
        chk("nolock_2good", int'(LOCK), 0);
        gap(996);
        chk("lock_after_3", int'(LOCK), 1);
        chk("locked_state", int'(STATE), 4);
        chk("clean_err", int'(ERR_CNT), 0);

        // Pulses stop while locked: two timeouts drop lock
        gap(1000);
        n = 0;
        syncs = 0;
        do begin
            step();
            n++;
            syncs += int'(SYNC_VLOCK);
        end while (STATE == 3'd4 && n < 3000);
        chk("loss_in_bound", int'(n < 3000), 1);
        chk("lost_state", int'(STATE), 5);
        chk("lost_lock", int'(LOCK), 0);
        chk("lost_err", int'(ERR_CNT), 2);
`ifdef MRX_SYNC_FLYWHEEL_EN
        chk("flywheel_pulses", syncs, 2);
`else
        chk("flywheel_pulses", syncs, 0);
`endif
        step();
        chk("lost_to_clear", int'(STATE), 1);
        finish_clear();

        // Bad pulse in TRACK resets the good count
        gap(1);
        gap(1005);
        chk("track_bad_err", int'(ERR_CNT), 3);
        chk("track_bad_state", int'(STATE), 3);
        gap(1000);
        gap(1000);
        chk("track_relock_2", int'(STATE), 3);
        gap(1000);
        chk("track_relock_3", int'(STATE), 4);

        // Pulse on the timeout cycle counts as a bad pulse
        gap(1005);
        chk("coinc_err", int'(ERR_CNT), 4);
        chk("coinc_state", int'(STATE), 4);
        chk("coinc_sync", int'(SYNC_VLOCK), 0);
        gap(1000);
        gap(990);
        chk("miss_cleared", int'(STATE), 4);
        chk("miss_err", int'(ERR_CNT), 5);
        gap(994);
        chk("bad_loss", int'(STATE), 5);
        chk("bad_loss_err", int'(ERR_CNT), 6);
        step();
        finish_clear();

        // TRACK timeout back to SEARCH
        gap(1);
        repeat (1004) step();
        chk("track_pre_tmo", int'(STATE), 3);
        step();
        chk("track_tmo_state", int'(STATE), 2);
        chk("track_tmo_err", int'(ERR_CNT), 7);

        // EN drop forces IDLE and keeps ERR_CNT
        gap(1);
        EN = 1'b0;
        step();
        chk("en_off_state", int'(STATE), 0);
        chk("en_off_err", int'(ERR_CNT), 7);

        // Reset in the middle of CLEAR
        EN = 1'b1;
        repeat (4) step();
        chk("mid_clear", int'(MRX_CLEAR), 1);
        RST = 1'b1;
        step();
        chk("rst_clear_out", int'(MRX_CLEAR), 0);
        chk("rst_clear_state", int'(STATE), 0);
        chk("rst_clear_err", int'(ERR_CNT), 0);
        RST = 1'b0;

        // Saturation: back-to-back pulses in TRACK are all bad
        step();
        chk("restart_clear", int'(STATE), 1);
        finish_clear();
        gap(1);
        MRX_FLAG_RE = 1'b1;
        repeat (300) step();
        chk("err_sat", int'(ERR_CNT), 255);
        ERR_CLR = 1'b1;
        step();
        chk("err_clr_wins", int'(ERR_CNT), 0);
        ERR_CLR = 1'b0;
        step();
        chk("err_after_clr", int'(ERR_CNT), 1);
        MRX_FLAG_RE = 1'b0;

        // Reset while locked
        gap(1000);
        gap(1000);
        gap(1000);
        chk("relock", int'(LOCK), 1);
        RST = 1'b1;
        step();
        chk("rst_locked_lock", int'(LOCK), 0);
        chk("rst_locked_state", int'(STATE), 0);
        chk("rst_locked_sync", int'(SYNC_VLOCK), 0);
        chk("rst_locked_clear", int'(MRX_CLEAR), 0);
        chk("rst_locked_err", int'(ERR_CNT), 0);
        RST = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
